// File: rtl/axis_zoh_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_zoh_pkg
// Purpose  : Shared types and constants for the ZOH upsampler slice.
//            zoh_state_e    - output FSM state (EMPTY: nothing held yet,
//                             RUN: a frame is being repeated)
//            UNDERRUN_CNT_W - width of the optional underrun statistic
// Revision : 1.0 - initial release
// ============================================================================
package axis_zoh_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } zoh_state_e;

  localparam int UNDERRUN_CNT_W = 32;

endpackage : axis_zoh_pkg
`default_nettype wire

// File: rtl/axis_zoh_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_zoh_if
// Purpose  : AXI-Stream bundle used on both sides of the upsampler.
// Ports    : tdata  - CHANNELS*WIDTH packed frame, ch0 in LSBs
//            tvalid - source has a beat
//            tready - sink accepts the beat
//            tlast  - final repeat of a frame (master side only)
//            master modport drives tdata/tvalid/tlast, slave drives tready.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_zoh_if #(
  parameter int DW = 48
);

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface : axis_zoh_if
`default_nettype wire

// File: rtl/axis_zoh_pend_slot.sv
`default_nettype none
// ============================================================================
// Module   : axis_zoh_pend_slot
// Purpose  : One-entry holding register for the next input frame.
// Ports    : aclk, arst_n - clock, synchronous active-low reset
//            din          - incoming frame
//            load         - an input handshake happened while running
//            consume      - the held frame is being moved into cur
//            bypass       - the input goes straight to cur this cycle, so
//                           the slot must not capture it
//            pend         - stored frame
//            pend_vld     - slot occupied
// Revision : 1.0 - initial release
// ============================================================================
module axis_zoh_pend_slot #(
  parameter int DW = 48
) (
  input  wire logic          aclk,
  input  wire logic          arst_n,
  input  wire logic [DW-1:0] din,
  input  wire logic          load,
  input  wire logic          consume,
  input  wire logic          bypass,
  output logic      [DW-1:0] pend,
  output logic               pend_vld
);

  logic [DW-1:0] r_pend;
  logic          r_pend_vld;
  logic          w_capture;

  assign w_capture = load & ~bypass;

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_capture) begin
        r_pend <= din;
      end
      // A capture in the same cycle as a consume refills the slot.
      if (w_capture) begin
        r_pend_vld <= 1'b1;
      end else if (consume) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign pend     = r_pend;
  assign pend_vld = r_pend_vld;

endmodule : axis_zoh_pend_slot
`default_nettype wire

// File: rtl/axis_zoh_upsampler.sv
`default_nettype none
// ============================================================================
// Module   : axis_zoh_upsampler
// Purpose  : Multi-channel zero-order-hold upsampler. Every accepted input
//            frame is emitted R times; a one-frame pending slot absorbs input
//            jitter, and on underrun the current frame repeats gap-free.
// Ports    : aclk, arst_n  - clock, synchronous active-low reset
//            s_axis        - input frames (slave)
//            m_axis        - held frames, tlast on the R-th repeat (master)
//            underrun      - 1-cycle pulse after a forced repeat
//            underrun_cnt  - saturating underrun count
//            stats_clr     - synchronous clear of underrun_cnt
// Config   : AXIS_ZOH_STATS_EN - enables the underrun counter; when
//            undefined underrun_cnt is 0 and stats_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module axis_zoh_upsampler
  import axis_zoh_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 2,
  parameter int R        = 100,
  parameter int PH_W     = $clog2(R + 1)
) (
  input  wire logic                      aclk,
  input  wire logic                      arst_n,
  axis_zoh_if.slave                      s_axis,
  axis_zoh_if.master                     m_axis,
  output logic                           underrun,
  output logic [UNDERRUN_CNT_W-1:0]      underrun_cnt,
  input  wire logic                      stats_clr
);

  localparam int              DW      = WIDTH * CHANNELS;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

  zoh_state_e      r_state, w_state_nxt;
  logic [DW-1:0]   r_cur, w_cur_nxt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic [DW-1:0]   w_pend;
  logic            w_pend_vld;
  logic            w_s_hs, w_m_hs, w_last_hs;
  logic            w_pend_load, w_pend_consume, w_pend_bypass;
  logic            w_underrun_evt;
  logic            r_underrun;

  // m_tvalid is exactly "in RUN", so it is a flop output.
  assign w_m_hs    = (r_state == RUN) & m_axis.tready;
  assign w_last_hs = w_m_hs & (r_phase == PH_LAST);

  // Ready only depends on the slot flag and the output side, never on
  // s_tvalid, so no combinational loop through the input handshake.
  assign s_axis.tready = ~w_pend_vld | w_last_hs;
  assign w_s_hs        = s_axis.tvalid & s_axis.tready;

  assign w_pend_load    = (r_state == RUN) & w_s_hs;
  assign w_pend_consume = w_last_hs & w_pend_vld;
  assign w_pend_bypass  = w_last_hs & ~w_pend_vld;

  axis_zoh_pend_slot #(
    .DW (DW)
  ) u_pend_slot (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .din      (s_axis.tdata),
    .load     (w_pend_load),
    .consume  (w_pend_consume),
    .bypass   (w_pend_bypass),
    .pend     (w_pend),
    .pend_vld (w_pend_vld)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_phase_nxt    = r_phase;
    w_underrun_evt = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_s_hs) begin
          w_cur_nxt   = s_axis.tdata;
          w_phase_nxt = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last_hs) begin
          w_phase_nxt = '0;
          if (w_pend_vld) begin
            w_cur_nxt = w_pend;
          end else if (w_s_hs) begin
            w_cur_nxt = s_axis.tdata;
          end else begin
            // Nothing new to hold: repeat cur and flag it.
            w_underrun_evt = 1'b1;
          end
        end else if (w_m_hs) begin
          w_phase_nxt = r_phase + PH_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_state    <= EMPTY;
      r_cur      <= '0;
      r_phase    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_phase    <= w_phase_nxt;
      r_underrun <= w_underrun_evt;
    end
  end

  assign m_axis.tvalid = (r_state == RUN);
  assign m_axis.tdata  = r_cur;
  assign m_axis.tlast  = (r_state == RUN) & (r_phase == PH_LAST);
  assign underrun      = r_underrun;

`ifdef AXIS_ZOH_STATS_EN
  logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

  // Clear has priority over a same-cycle increment; count saturates.
  always_ff @(posedge aclk) begin
    if (!arst_n || stats_clr) begin
      r_underrun_cnt <= '0;
    end else if (r_underrun && (r_underrun_cnt != '1)) begin
      r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign underrun_cnt       = '0;
`endif

endmodule : axis_zoh_upsampler
`default_nettype wire
